// File: rtl/spi_reg_pkg.sv
// Shared widths, R/W encodings and controller state type for the SPI register writer.
package spi_reg_pkg;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned DATA_W  = 8;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
endpackage

// File: rtl/spi_tick_gen.sv
// Free-running divider: one-cycle tick on the last of every CLK_DIV counts; clr restarts at zero.
module spi_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/spi_reg_writer.sv
// Mode-0 SPI initiator sending {rw, addr, data} frames MSB first.
// Optional read-back on cipo into rd_data when SPI_REG_WRITER_CIPO_EN is defined.
module spi_reg_writer
  import spi_reg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              sclk,
  output logic              copi,
  output logic              ncs,
  output logic              busy,
  output logic              done
`ifdef SPI_REG_WRITER_CIPO_EN
  ,
  input  logic              cipo,
  output logic [DATA_W-1:0] rd_data
`endif
);
  state_t               state;
  logic [FRAME_W-1:0]   frame;
  logic [3:0]           bit_idx;
  logic                 tick;
  logic                 tick_clr;
`ifdef SPI_REG_WRITER_CIPO_EN
  logic [DATA_W-1:0]    rd_shift;
`endif

  assign cmd_ready = (state == IDLE);
  assign tick_clr  = (state == IDLE);

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      frame   <= '0;
      bit_idx <= '0;
      sclk    <= 1'b0;
      copi    <= 1'b0;
      ncs     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SPI_REG_WRITER_CIPO_EN
      rd_shift <= '0;
      rd_data  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            frame   <= {cmd_rw, cmd_addr, cmd_data};
            ncs     <= 1'b0;
            copi    <= cmd_rw;
            busy    <= 1'b1;
            bit_idx <= 4'd15;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            sclk  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (sclk) begin
              // Falling edge: present the next bit, or finish after bit 0 keeping copi at bit 0.
              sclk <= 1'b0;
`ifdef SPI_REG_WRITER_CIPO_EN
              if (bit_idx <= 4'd7) rd_shift <= {rd_shift[DATA_W-2:0], cipo};
`endif
              if (bit_idx == 4'd0) begin
                state <= HOLD;
              end else begin
                bit_idx <= bit_idx - 4'd1;
                copi    <= frame[bit_idx - 4'd1];
              end
            end else begin
              sclk <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            ncs   <= 1'b1;
            copi  <= 1'b0;
            done  <= 1'b1;
            state <= GAP;
`ifdef SPI_REG_WRITER_CIPO_EN
            rd_data <= rd_shift;
`endif
          end
        end
        GAP: begin
          if (tick) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_reg_writer.sv
// Scoreboard bench for spi_reg_writer: bit-collecting peripheral model plus frame/timing checks.
module tb_spi_reg_writer;
  import spi_reg_pkg::*;

  localparam int unsigned CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       cmd_ready, sclk, copi, ncs, busy, done;
`ifdef SPI_REG_WRITER_CIPO_EN
  logic       cipo_drv = 1'b0;
  logic [7:0] rd_data;
`endif

  always #5 clk = ~clk;

  spi_reg_writer #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .sclk      (sclk),
    .copi      (copi),
    .ncs       (ncs),
    .busy      (busy),
    .done      (done)
`ifdef SPI_REG_WRITER_CIPO_EN
    ,
    .cipo      (cipo_drv),
    .rd_data   (rd_data)
`endif
  );

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  rd;
  } exp_t;
  exp_t       exp_q[$];
  logic [7:0] ref_regs[128];
  logic [7:0] per_regs[128];
  bit         abort_expected = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Peripheral model and monitor: collect bits on sclk rises while ncs is low, judge on ncs rise.
  logic        prev_ncs = 1'b1, prev_sclk = 1'b0;
  int          low_cnt = 0, rises = 0, gap_cnt = 0, high_cnt = 0;
  bit          gap_active = 1'b0, have_prev = 1'b0;
  logic [15:0] sh = '0;
  logic [6:0]  rd_addr = '0;

  always @(negedge clk) begin
    bit   fell, rose;
    exp_t e;
    fell = prev_ncs && !ncs;
    rose = !prev_ncs && ncs;
    if (fell) begin
      low_cnt = 1;
      rises   = 0;
      sh      = '0;
      chk("busy_at_ncs_fall", busy, 1);
      if (have_prev) chk("ncs_high_gap_ge_div", (high_cnt >= CLK_DIV), 1);
    end else if (!ncs) begin
      low_cnt++;
    end
    if (rose) high_cnt = 1;
    else if (ncs) high_cnt++;

    if (!ncs && !prev_sclk && sclk) begin
      rises++;
      sh = {sh[14:0], copi};
      if (rises == 8) rd_addr = sh[6:0];
`ifdef SPI_REG_WRITER_CIPO_EN
      if (rises >= 9 && rises <= 16) begin
        logic [7:0] pv;
        pv = per_regs[rd_addr];
        cipo_drv = pv[16 - rises];
      end
`endif
    end

    if (rose) begin
`ifdef SPI_REG_WRITER_CIPO_EN
      cipo_drv = 1'b0;
`endif
      if (abort_expected) begin
        chk("abort_no_done", done, 0);
        chk("abort_rises_before_reset", rises, 5);
        abort_expected = 1'b0;
        have_prev = 1'b0;
      end else begin
        chk("done_at_ncs_rise", done, 1);
        chk("ncs_low_cycles", low_cnt, 33 * CLK_DIV);
        chk("sclk_rises_per_frame", rises, 16);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected: got 0x%0h, required no frame", sh);
        end else begin
          e = exp_q.pop_front();
          chk("frame", sh, e.frame);
          if (rises == 16 && sh[15] == RW_WRITE) per_regs[sh[14:8]] = sh[7:0];
`ifdef SPI_REG_WRITER_CIPO_EN
          if (e.frame[15] == RW_READ) chk("rd_data_at_done", rd_data, e.rd);
`endif
        end
        gap_active = 1'b1;
        gap_cnt    = 0;
        have_prev  = 1'b1;
      end
    end else if (done) begin
      checks++;
      errors++;
      $display("FAIL done_without_ncs_rise: got 1, required 0 (t=%0t)", $time);
    end

    if (gap_active && !rose) begin
      gap_cnt++;
      if (gap_cnt == 1) chk("done_single_cycle", done, 0);
      if (cmd_ready) begin
        chk("cmd_ready_after_done", gap_cnt, CLK_DIV);
        chk("busy_clear_at_idle", busy, 0);
        gap_active = 1'b0;
      end else if (gap_cnt > 50) begin
        checks++;
        errors++;
        $display("FAIL cmd_ready_return_timeout: got 0, required 1");
        gap_active = 1'b0;
      end
    end
    prev_ncs  = ncs;
    prev_sclk = sclk;
  end

  task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d,
                      input bit hold_valid, input bit expect_frame,
                      output int unsigned acc_cyc);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = a;
    cmd_data  = d;
    while (!cmd_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got cmd_ready=0, required 1");
    end
    if (expect_frame) begin
      e.frame = {rw, a, d};
      e.rd    = ref_regs[a];
      exp_q.push_back(e);
      if (rw == RW_WRITE) ref_regs[a] = d;
    end
    @(negedge clk);
    acc_cyc = cyc;
    if (!hold_valid) cmd_valid = 1'b0;
    chk("cmd_ready_low_after_accept", cmd_ready, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0, t1;
    int          w;
    for (int i = 0; i < 128; i++) begin
      ref_regs[i] = '0;
      per_regs[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("reset_ncs", ncs, 1);
      chk("reset_sclk", sclk, 0);
      chk("reset_copi", copi, 0);
      chk("reset_cmd_ready", cmd_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
`ifdef SPI_REG_WRITER_CIPO_EN
      chk("reset_rd_data", rd_data, 0);
`endif
    end

    send(1'b1, 7'h00, 8'hFF, 1'b0, 1'b1, t0);

    send(1'b1, 7'h04, 8'hA5, 1'b1, 1'b1, t0);
    send(1'b1, 7'h02, 8'h3C, 1'b0, 1'b1, t1);
    chk("back_to_back_accept_spacing", t1 - t0, 34 * CLK_DIV + 1);

    send(1'b1, 7'h01, 8'h55, 1'b0, 1'b1, t0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_addr  = 7'($urandom);
      cmd_data  = 8'($urandom);
      if (i % 10 == 0) chk("cmd_ready_low_mid_frame", cmd_ready, 0);
    end
    cmd_valid = 1'b0;

    send(1'b1, 7'h03, 8'h77, 1'b0, 1'b0, t0);
    repeat (38) @(negedge clk);
    abort_expected = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ncs_async", ncs, 1);
    chk("abort_sclk_async", sclk, 0);
    chk("abort_done_async", done, 0);
    chk("abort_cmd_ready_async", cmd_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("abort_reg3_unchanged", per_regs[3], ref_regs[3]);

    send(1'b1, 7'h03, 8'h12, 1'b0, 1'b1, t0);

    send(1'b1, 7'h01, 8'h5A, 1'b0, 1'b1, t0);
    send(1'b0, 7'h01, 8'h00, 1'b0, 1'b1, t0);

    for (int i = 0; i < 20; i++) begin
      send(1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), 8'($urandom), 1'b0, 1'b1, t0);
    end

    w = 0;
    while ((exp_q.size() != 0 || !cmd_ready || gap_active) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("reg0_is_ff", per_regs[0], 8'hFF);
    chk("reg3_is_12", per_regs[3], 8'h12);
    for (int i = 0; i < 16; i++) chk("register_file", per_regs[i], ref_regs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
